// File: rtl/tmds_frame_sequencer.sv
// Raster timing generator for a TMDS encoder: counters, blank, sync/control data, guard band.
// Define TMDS_SEQ_PREAMBLE_EN for HDMI video preamble and leading guard band (DVI framing otherwise).
module tmds_frame_sequencer #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        blank,
    output logic [1:0]  cd0,
    output logic [1:0]  cd1,
    output logic [1:0]  cd2,
    output logic        guard,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        line_start,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        HS_ON    = (HSYNC_POL != 0);
    localparam logic        VS_ON    = (VSYNC_POL != 0);
`ifdef TMDS_SEQ_PREAMBLE_EN
    localparam logic [11:0] PRE_START = 12'(H_TOTAL - 10);
    localparam logic [11:0] PRE_END   = 12'(H_TOTAL - 3);
    localparam logic [11:0] GB_START  = 12'(H_TOTAL - 2);
    localparam logic [11:0] V_PRE_LIM = 12'(V_ACTIVE - 1);
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;
    logic        blank_d, guard_d, ls_d, fs_d;
    logic [1:0]  cd0_d, cd1_d, cd2_d;
    logic [11:0] x_d, y_d;

    // Run/idle control and raster counters; stopping is only allowed on the last pixel of a frame.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            ST_IDLE: begin
                h_d = 12'd0;
                v_d = 12'd0;
                if (enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (h_q == H_LAST) begin
                    h_d = 12'd0;
                    if (v_q == V_LAST) begin
                        v_d = 12'd0;
                        if (!enable) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        v_d = v_q + 12'd1;
                    end
                end else begin
                    h_d = h_q + 12'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_d     = 12'd0;
                v_d     = 12'd0;
            end
        endcase
    end

    // Decode the current (h,v) into the encoder controls registered for the next cycle.
    always_comb begin
        blank_d = 1'b1;
        cd0_d   = {~VS_ON, ~HS_ON};
        cd1_d   = 2'b00;
        cd2_d   = 2'b00;
        guard_d = 1'b0;
        x_d     = 12'd0;
        y_d     = 12'd0;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        if (state_q == ST_RUN) begin
            blank_d  = !((h_q < H_ACT) && (v_q < V_ACT));
            cd0_d[1] = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_ON : ~VS_ON;
            cd0_d[0] = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_ON : ~HS_ON;
            x_d      = h_q;
            y_d      = v_q;
            ls_d     = (h_q == 12'd0);
            fs_d     = (h_q == 12'd0) && (v_q == 12'd0);
`ifdef TMDS_SEQ_PREAMBLE_EN
            // Preamble and guard band sit in the back porch of lines that precede an active line.
            if (((v_q < V_PRE_LIM) || (v_q == V_LAST)) && (h_q >= PRE_START) && (h_q <= PRE_END)) begin
                cd1_d = 2'b01;
            end else begin
                cd1_d = 2'b00;
            end
            if (((v_q < V_PRE_LIM) || (v_q == V_LAST)) && (h_q >= GB_START)) begin
                guard_d = 1'b1;
            end else begin
                guard_d = 1'b0;
            end
`endif
        end else begin
            blank_d = 1'b1;
            guard_d = 1'b0;
        end
    end

    // State, counters and all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            h_q         <= 12'd0;
            v_q         <= 12'd0;
            blank       <= 1'b1;
            cd0         <= {~VS_ON, ~HS_ON};
            cd1         <= 2'b00;
            cd2         <= 2'b00;
            guard       <= 1'b0;
            x           <= 12'd0;
            y           <= 12'd0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            blank       <= blank_d;
            cd0         <= cd0_d;
            cd1         <= cd1_d;
            cd2         <= cd2_d;
            guard       <= guard_d;
            x           <= x_d;
            y           <= y_d;
            line_start  <= ls_d;
            frame_start <= fs_d;
        end
    end
endmodule

// File: tb/tb_tmds_frame_sequencer.sv
// Scoreboard bench: a pixel-index reference model queues expected outputs, a monitor compares.
module tb_tmds_frame_sequencer;
    localparam int HA = 16, HFP = 2, HS = 3, HBP = 10;
    localparam int VA = 6, VFP = 1, VS = 2, VBP = 2;
    localparam int HPOL = 0, VPOL = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int NPIX = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        blank, guard, line_start, frame_start;
    logic [1:0]  cd0, cd1, cd2;
    logic [11:0] x, y;

    typedef struct packed {
        logic        blank;
        logic [1:0]  cd0;
        logic [1:0]  cd1;
        logic [1:0]  cd2;
        logic        guard;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   frames_seen = 0;
    bit   running = 1'b0;
    int   pix = 0;

    tmds_frame_sequencer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .blank(blank), .cd0(cd0), .cd1(cd1), .cd2(cd2), .guard(guard),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic out_t idle_out();
        out_t o;
        o = '0;
        o.blank = 1'b1;
        o.cd0 = {(VPOL != 0) ? 1'b0 : 1'b1, (HPOL != 0) ? 1'b0 : 1'b1};
        return o;
    endfunction

    // Expected outputs for linear pixel position p within a frame.
    function automatic out_t pixel_out(input int p);
        out_t o;
        int h, v;
        bit nxt_act;
        h = p % HT;
        v = p / HT;
        o = '0;
        o.blank = !(h < HA && v < VA);
        o.cd0[1] = (v >= VA + VFP && v < VA + VFP + VS) ? (VPOL != 0) : (VPOL == 0);
        o.cd0[0] = (h >= HA + HFP && h < HA + HFP + HS) ? (HPOL != 0) : (HPOL == 0);
        o.x = 12'(h);
        o.y = 12'(v);
        o.ls = (h == 0);
        o.fs = (p == 0);
`ifdef TMDS_SEQ_PREAMBLE_EN
        nxt_act = (v < VA - 1) || (v == VT - 1);
        if (nxt_act && h >= HT - 10 && h <= HT - 3) o.cd1 = 2'b01;
        if (nxt_act && h >= HT - 2) o.guard = 1'b1;
`else
        nxt_act = 1'b0;
`endif
        return o;
    endfunction

    // Reference model: predicts the value each output register takes at this edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running = 1'b0;
            pix = 0;
            exp_q.delete();
        end else begin
            if (running) begin
                exp_q.push_back(pixel_out(pix));
                if (pix == NPIX - 1 && !enable) begin
                    running = 1'b0;
                    pix = 0;
                end else begin
                    pix = (pix + 1) % NPIX;
                end
            end else begin
                exp_q.push_back(idle_out());
                if (enable) begin
                    running = 1'b1;
                    pix = 0;
                end
            end
        end
    end

    // Monitor: sample away from the rising edge and compare against the scoreboard.
    always @(negedge clk) begin
        out_t got, exp;
        got = '{blank, cd0, cd1, cd2, guard, x, y, line_start, frame_start};
        if (!rst_n) begin
            exp = idle_out();
        end else if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
        end else begin
            exp = got;
        end
        if (!rst_n || exp_q.size() >= 0) begin
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL outputs t=%0t got x=%0d y=%0d blank=%b cd0=%b cd1=%b cd2=%b guard=%b ls=%b fs=%b exp x=%0d y=%0d blank=%b cd0=%b cd1=%b cd2=%b guard=%b ls=%b fs=%b",
                         $time, got.x, got.y, got.blank, got.cd0, got.cd1, got.cd2, got.guard, got.ls, got.fs,
                         exp.x, exp.y, exp.blank, exp.cd0, exp.cd1, exp.cd2, exp.guard, exp.ls, exp.fs);
            end
        end
        if (guard === 1'b1) begin
            checks++;
            if (blank !== 1'b1) begin
                errors++;
                $display("FAIL guard_blank t=%0t got blank=%b required 1", $time, blank);
            end
        end
        if (rst_n && frame_start === 1'b1) frames_seen++;
    end

    task automatic run_cycles(input int n, input bit en);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1 enable = en;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        run_cycles(2 * NPIX + 5, 1'b1);
        // Drop enable mid-frame: frame must complete, then idle.
        run_cycles(NPIX + 40, 1'b0);
        run_cycles(NPIX / 2, 1'b1);
        // Asynchronous reset mid-frame, released with enable low.
        @(negedge clk);
        #2 rst_n = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        run_cycles(20, 1'b0);
        run_cycles(NPIX + 10, 1'b1);
        // Random enable segments of varying length.
        for (int s = 0; s < 20; s++) begin
            run_cycles(int'($urandom_range(1, 2 * NPIX)), 1'($urandom_range(0, 1)));
        end
        run_cycles(NPIX + 10, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (frames_seen < 4) begin
            errors++;
            $display("FAIL frame_count got %0d required at least 4", frames_seen);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
